// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and HI/LO interlocks against a multicycle
// MDU, producing PC/IF-ID hold, IF-ID flush, ID-EX bubble and a stall counter.
module hazard_ctrl #(
    parameter int unsigned MD_CYCLES   = 5,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_wreg,
    input  logic                   id_md_start,
    input  logic                   id_md_access,
    input  logic                   id_branch_tk,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned CntW = $clog2(MD_CYCLES) + 1;
    localparam logic [CntW-1:0] CntInit = CntW'(MD_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } md_state_e;

    md_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic busy;
    logic rs_match;
    logic rt_match;
    logic load_use;
    logic md_stall;
    logic stall;

    assign busy     = (state_q == StBusy);
    assign rs_match = id_rs_used & (id_rs == ex_wreg);
    assign rt_match = id_rt_used & (id_rt == ex_wreg);
    // $0 is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read & (ex_wreg != 5'd0) & (rs_match | rt_match);
    assign md_stall = id_md_access & busy;
    assign stall    = load_use | md_stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (id_md_start && !stall) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are gated by reset so they drop immediately on an asynchronous assert.
    assign pc_hold     = stall & ~reset;
    assign ifid_hold   = stall & ~reset;
    assign idex_bubble = stall & ~reset;
    assign ifid_flush  = id_branch_tk & ~stall & ~reset;
    assign md_busy     = busy & ~reset;
    assign stall_cnt   = stall_cnt_q;

endmodule
